// File: rtl/mem_wb_writeback.sv
// MEM->WB pipeline register, write-back select, 32-entry register file and retire/load counters.
// Optional feature: define WB_BYPASS_EN for write-through reads during the write cycle.
module mem_wb_writeback #(
  parameter int unsigned WORD_LEN     = 32,
  parameter int unsigned REG_ADDR_LEN = 5,
  parameter int unsigned CNT_LEN      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_MEM,
  input  logic                    WB_EN_MEM,
  input  logic                    MEM_R_EN_MEM,
  input  logic [WORD_LEN-1:0]     ALURes_MEM,
  input  logic [WORD_LEN-1:0]     dataMem_out_MEM,
  input  logic [REG_ADDR_LEN-1:0] dest_MEM,
  input  logic [REG_ADDR_LEN-1:0] src1,
  input  logic [REG_ADDR_LEN-1:0] src2,
  input  logic                    clr_cnt,
  output logic [WORD_LEN-1:0]     reg1,
  output logic [WORD_LEN-1:0]     reg2,
  output logic [WORD_LEN-1:0]     WB_result,
  output logic [REG_ADDR_LEN-1:0] dest_WB,
  output logic                    WB_EN_WB,
  output logic [CNT_LEN-1:0]      retire_cnt,
  output logic [CNT_LEN-1:0]      load_cnt
);

  localparam int unsigned NUM_REGS = 2 ** REG_ADDR_LEN;
  localparam logic [CNT_LEN-1:0] CNT_MAX = {CNT_LEN{1'b1}};

  typedef struct packed {
    logic                    valid;
    logic                    wb_en;
    logic                    mem_r_en;
    logic [WORD_LEN-1:0]     alu_res;
    logic [WORD_LEN-1:0]     mem_data;
    logic [REG_ADDR_LEN-1:0] dest;
  } mem2wb_t;

  mem2wb_t             pipe_q, pipe_d;
  logic [WORD_LEN-1:0] regs_q [NUM_REGS];
  logic [CNT_LEN-1:0]  retire_q, retire_d;
  logic [CNT_LEN-1:0]  load_q, load_d;

  // MEM2WB capture: no stall, bubbles propagate as valid=0
  always_comb begin
    pipe_d          = '0;
    pipe_d.valid    = valid_MEM;
    pipe_d.wb_en    = WB_EN_MEM;
    pipe_d.mem_r_en = MEM_R_EN_MEM;
    pipe_d.alu_res  = ALURes_MEM;
    pipe_d.mem_data = dataMem_out_MEM;
    pipe_d.dest     = dest_MEM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Write-back select and effective enable; r0 is never a write target
  always_comb begin
    WB_result = pipe_q.mem_r_en ? pipe_q.mem_data : pipe_q.alu_res;
    dest_WB   = pipe_q.dest;
    WB_EN_WB  = pipe_q.valid & pipe_q.wb_en & (pipe_q.dest != '0);
  end

  // Register file; reset clears the array and drops any in-flight write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (WB_EN_WB) begin
      regs_q[dest_WB] <= WB_result;
    end
  end

  // Read ports
  always_comb begin
    reg1 = '0;
    reg2 = '0;
    if (src1 != '0) begin
      reg1 = regs_q[src1];
    end
    if (src2 != '0) begin
      reg2 = regs_q[src2];
    end
`ifdef WB_BYPASS_EN
    if (WB_EN_WB && (src1 == dest_WB)) begin
      reg1 = WB_result;
    end
    if (WB_EN_WB && (src2 == dest_WB)) begin
      reg2 = WB_result;
    end
`endif
  end

  // Saturating statistics counters; clear beats a same-cycle increment
  always_comb begin
    retire_d = retire_q;
    load_d   = load_q;
    if (clr_cnt) begin
      retire_d = '0;
      load_d   = '0;
    end else begin
      if (pipe_q.valid && (retire_q != CNT_MAX)) begin
        retire_d = retire_q + CNT_LEN'(1);
      end
      if (pipe_q.valid && pipe_q.mem_r_en && (load_q != CNT_MAX)) begin
        load_d = load_q + CNT_LEN'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
      load_q   <= '0;
    end else begin
      retire_q <= retire_d;
      load_q   <= load_d;
    end
  end

  assign retire_cnt = retire_q;
  assign load_cnt   = load_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed, table-driven bench for mem_wb_writeback (narrow counters to reach saturation quickly).
module tb_mem_wb_writeback;

  localparam int unsigned CW = 4;

  logic        clk, rst, valid_MEM, WB_EN_MEM, MEM_R_EN_MEM, clr_cnt;
  logic [31:0] ALURes_MEM, dataMem_out_MEM;
  logic [4:0]  dest_MEM, src1, src2;
  logic [31:0] reg1, reg2, WB_result;
  logic [4:0]  dest_WB;
  logic        WB_EN_WB;
  logic [CW-1:0] retire_cnt, load_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_writeback #(.WORD_LEN(32), .REG_ADDR_LEN(5), .CNT_LEN(CW)) dut (
    .clk(clk), .rst(rst), .valid_MEM(valid_MEM), .WB_EN_MEM(WB_EN_MEM),
    .MEM_R_EN_MEM(MEM_R_EN_MEM), .ALURes_MEM(ALURes_MEM), .dataMem_out_MEM(dataMem_out_MEM),
    .dest_MEM(dest_MEM), .src1(src1), .src2(src2), .clr_cnt(clr_cnt),
    .reg1(reg1), .reg2(reg2), .WB_result(WB_result), .dest_WB(dest_WB),
    .WB_EN_WB(WB_EN_WB), .retire_cnt(retire_cnt), .load_cnt(load_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        v, we, rd;
    logic [31:0] alu, mem;
    logic [4:0]  dest, s1, s2;
    logic [31:0] e_res;
    logic [4:0]  e_dest;
    logic        e_en;
    logic [31:0] e_r1, e_r2;
    int          e_ret, e_ld;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic rd, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [4:0] dest);
    valid_MEM = v; WB_EN_MEM = we; MEM_R_EN_MEM = rd;
    ALURes_MEM = alu; dataMem_out_MEM = mem; dest_MEM = dest;
  endtask

  function automatic vec_t mk(logic v, logic we, logic rd, logic [31:0] alu, logic [31:0] mem,
                              logic [4:0] dest, logic [4:0] s1, logic [4:0] s2,
                              logic [31:0] e_res, logic e_en, logic [31:0] e_r1,
                              logic [31:0] e_r2, int e_ret, int e_ld);
    vec_t t;
    t.v = v; t.we = we; t.rd = rd; t.alu = alu; t.mem = mem; t.dest = dest;
    t.s1 = s1; t.s2 = s2; t.e_res = e_res; t.e_dest = dest; t.e_en = e_en;
    t.e_r1 = e_r1; t.e_r2 = e_r2; t.e_ret = e_ret; t.e_ld = e_ld;
    return t;
  endfunction

  initial begin
    logic [31:0] byp_val;
`ifdef WB_BYPASS_EN
    byp_val = 32'hBEEF;
`else
    byp_val = 32'h1;
`endif
    // Each row: inputs presented, one edge, then WB outputs for that row; counters cover prior rows
    vecs[0] = mk(1, 1, 0, 32'h1234, 32'h0,    5'd5, 5'd0, 5'd0, 32'h1234, 1, 32'h0,    32'h0,    0, 0);
    vecs[1] = mk(1, 1, 1, 32'h40,   32'hCAFE, 5'd7, 5'd5, 5'd0, 32'hCAFE, 1, 32'h1234, 32'h0,    1, 0);
    vecs[2] = mk(1, 1, 0, 32'hFFFF, 32'h0,    5'd0, 5'd7, 5'd0, 32'hFFFF, 0, 32'hCAFE, 32'h0,    2, 1);
    vecs[3] = mk(0, 1, 1, 32'h5555, 32'h6666, 5'd3, 5'd0, 5'd5, 32'h6666, 0, 32'h0,    32'h1234, 3, 1);
    vecs[4] = mk(1, 0, 0, 32'h7777, 32'h0,    5'd3, 5'd3, 5'd7, 32'h7777, 0, 32'h0,    32'hCAFE, 3, 1);
    vecs[5] = mk(1, 1, 0, 32'h1,    32'h0,    5'd9, 5'd3, 5'd0, 32'h1,    1, 32'h0,    32'h0,    4, 1);
    vecs[6] = mk(1, 1, 0, 32'hBEEF, 32'h0,    5'd9, 5'd9, 5'd9, 32'hBEEF, 1, byp_val,  byp_val,  5, 1);
    vecs[7] = mk(0, 0, 0, 32'h0,    32'h0,    5'd0, 5'd9, 5'd5, 32'h0,    0, 32'hBEEF, 32'h1234, 6, 1);
    vecs[8] = mk(0, 0, 0, 32'h0,    32'h0,    5'd0, 5'd7, 5'd9, 32'h0,    0, 32'hCAFE, 32'hBEEF, 6, 1);

    // Reset with garbage on the inputs
    rst = 1'b1; clr_cnt = 1'b0; src1 = 5'd5; src2 = 5'd7;
    drive(1, 1, 1, 32'hDEAD, 32'hBEEF, 5'd5);
    step();
    chk("rst_wb_result", WB_result, 32'h0);
    chk("rst_wb_en", 32'(WB_EN_WB), 32'h0);
    chk("rst_reg1", reg1, 32'h0);
    chk("rst_reg2", reg2, 32'h0);
    chk("rst_retire", 32'(retire_cnt), 32'h0);
    chk("rst_load", 32'(load_cnt), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].v, vecs[i].we, vecs[i].rd, vecs[i].alu, vecs[i].mem, vecs[i].dest);
      src1 = vecs[i].s1; src2 = vecs[i].s2;
      step();
      chk($sformatf("v%0d_wb_result", i), WB_result, vecs[i].e_res);
      chk($sformatf("v%0d_dest_wb", i), 32'(dest_WB), 32'(vecs[i].e_dest));
      chk($sformatf("v%0d_wb_en", i), 32'(WB_EN_WB), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_reg1", i), reg1, vecs[i].e_r1);
      chk($sformatf("v%0d_reg2", i), reg2, vecs[i].e_r2);
      chk($sformatf("v%0d_retire", i), 32'(retire_cnt), 32'(vecs[i].e_ret));
      chk($sformatf("v%0d_load", i), 32'(load_cnt), 32'(vecs[i].e_ld));
    end

    // Clear in the same cycle a load retires: both counters go to 0
    drive(1, 0, 1, 32'h0, 32'h0, 5'd0);
    step();
    chk("pre_clr_retire", 32'(retire_cnt), 32'd6);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    clr_cnt = 1'b1;
    step();
    chk("clr_retire", 32'(retire_cnt), 32'd0);
    chk("clr_load", 32'(load_cnt), 32'd0);
    clr_cnt = 1'b0;
    step();
    chk("post_clr_retire", 32'(retire_cnt), 32'd0);

    // Saturation: 20 retiring loads into 4-bit counters
    drive(1, 0, 1, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 15; i++) step();
    chk("cnt_14_retire", 32'(retire_cnt), 32'd14);
    step();
    chk("cnt_15_load", 32'(load_cnt), 32'd15);
    for (int i = 0; i < 4; i++) step();
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    step();
    step();
    chk("sat_retire", 32'(retire_cnt), 32'd15);
    chk("sat_load", 32'(load_cnt), 32'd15);

    // Reset while a write is in WB: the write is dropped and counters clear
    drive(1, 1, 0, 32'hAAAA, 32'h0, 5'd4);
    step();
    chk("inflight_wb_en", 32'(WB_EN_WB), 32'h1);
    drive(0, 0, 0, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    src1 = 5'd4; src2 = 5'd9;
    chk("midrst_wb_en", 32'(WB_EN_WB), 32'h0);
    chk("midrst_retire", 32'(retire_cnt), 32'h0);
    step();
    chk("midrst_reg4", reg1, 32'h0);
    chk("midrst_reg9", reg2, 32'h0);
    chk("midrst_retire2", 32'(retire_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
